// File: rtl/seq_mult_unit.sv
// seq_mult_unit
// Multicycle unsigned shift-add multiplier. An accepted start latches the
// operands. WIDTH iterations then build the 2*WIDTH-bit product, and a
// one-cycle done pulse marks the moment the product registers become final.
//
// Ports:
//   clk        - system clock, rising edge
//   reset      - asynchronous, active-high reset
//   start      - request pulse, only sampled while idle
//   a, b       - multiplicand / multiplier, captured on the accepting edge
//   busy       - high while an operation is running or signalling done
//   done       - single-cycle pulse, product valid and final
//   product_lo - low WIDTH bits of a*b, held until the next operation completes
//   product_hi - high WIDTH bits of a*b, held likewise

module seq_mult_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product_lo,
   output logic [WIDTH-1:0] product_hi
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t               state_r;
   state_t               state_next_s;
   logic [2*WIDTH-1:0]   mcand_r;
   logic [WIDTH-1:0]     mplier_r;
   logic [2*WIDTH-1:0]   acc_r;
   logic [CW-1:0]        count_r;
   logic [WIDTH-1:0]     product_lo_r;
   logic [WIDTH-1:0]     product_hi_r;
   logic                 busy_r;
   logic                 done_r;
   logic                 last_iter_s;
   logic [2*WIDTH-1:0]   acc_next_s;

   // Iteration helpers: final-iteration flag and the accumulator including this edge's conditional add
   always_comb begin
      last_iter_s = (count_r == CW'(WIDTH - 1));
      if (mplier_r[0]) begin
         acc_next_s = acc_r + mcand_r;
      end else begin
         acc_next_s = acc_r;
      end
   end

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next-state logic; DONE always returns to IDLE so start is never queued
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (start) begin
               state_next_s = S_RUN;
            end else begin
               state_next_s = S_IDLE;
            end
         end
         S_RUN: begin
            if (last_iter_s) begin
               state_next_s = S_DONE;
            end else begin
               state_next_s = S_RUN;
            end
         end
         S_DONE:  state_next_s = S_IDLE;
         default: state_next_s = S_IDLE;
      endcase
   end

   // Status flags registered from the next state, so they track the state register exactly
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_r <= 1'b0;
         done_r <= 1'b0;
      end else begin
         busy_r <= (state_next_s != S_IDLE);
         done_r <= (state_next_s == S_DONE);
      end
   end

   // Shift-add datapath; the product registers change only on the final iteration
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         mcand_r      <= '0;
         mplier_r     <= '0;
         acc_r        <= '0;
         count_r      <= '0;
         product_lo_r <= '0;
         product_hi_r <= '0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (start) begin
                  mcand_r  <= {{WIDTH{1'b0}}, a};
                  mplier_r <= b;
                  acc_r    <= '0;
                  count_r  <= '0;
               end
            end
            S_RUN: begin
               acc_r    <= acc_next_s;
               mcand_r  <= mcand_r << 1;
               mplier_r <= mplier_r >> 1;
               count_r  <= count_r + CW'(1);
               if (last_iter_s) begin
                  product_hi_r <= acc_next_s[2*WIDTH-1:WIDTH];
                  product_lo_r <= acc_next_s[WIDTH-1:0];
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign busy       = busy_r;
   assign done       = done_r;
   assign product_lo = product_lo_r;
   assign product_hi = product_hi_r;

endmodule
